msg_enable_ctrl: RTL
====================

// Module: msg_enable_ctrl
// PURPOSE
//  Parametrised message-enable sequencer for the SHA-256 core; successor to the single-bit enable flop.
//  On start it runs ROUNDS compression rounds for each of num_blocks 512-bit blocks.
//  Per round it drives enable, round_idx and a message-load strobe for the first LOAD_WORDS rounds.
//  It inserts one digest-update cycle per block, then pulses done.
//  Sits between the top-level control and the message scheduler / compression datapath.
// PARAMETERS
//  ROUNDS     64  compression rounds per block (>=LOAD_WORDS, >=2)
//  LOAD_WORDS 16  rounds in which message words W0..W15 are loaded from input
//  RND_W      6   width of round_idx; 2**RND_W >= ROUNDS
//  BLK_W      8   width of num_blocks / block_idx
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  start       in   1      begin job; sampled only in IDLE
//  num_blocks  in   BLK_W  block count; latched on accepted start
//  stall       in   1      freeze round progress (upstream data not ready)
//  abort       in   1      cancel job; return to IDLE, no done
//  enable      out  1      round step this cycle = (state==RUN) & !stall (only comb path from input)
//  load_en     out  1      enable & (round_idx < LOAD_WORDS)
//  round_idx   out  RND_W  current round 0..ROUNDS-1
//  block_idx   out  BLK_W  current block 0..num_blocks-1
//  block_done  out  1      1-cycle pulse in UPDATE state
//  done        out  1      1-cycle pulse after last block's UPDATE
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; round_idx=0, block_idx=0, latched count=0; all 1-bit outputs 0.
//  Reset has priority over abort; abort has priority over all other inputs.
//  Abort in any state: next cycle IDLE, counters 0, no block_done/done.
//  States: IDLE, RUN, UPDATE, DONE.
//  IDLE:
//   - start=1 & num_blocks!=0 -> RUN; latch count; round_idx=0, block_idx=0.
//   - start=1 & num_blocks==0 -> ignored, stays IDLE, no done.
//  RUN:
//   - stall=1 -> hold all registers.
//   - stall=0 & round_idx<ROUNDS-1 -> round_idx+1.
//   - stall=0 & round_idx==ROUNDS-1 -> UPDATE, round_idx=0.
//  UPDATE (1 cycle, ignores stall):
//   - block_done=1, enable=0.
//   - block_idx==count-1 -> DONE; else block_idx+1 -> RUN.
//  DONE (1 cycle): done=1, busy=1 -> IDLE; block_idx cleared to 0.
//  start while busy is ignored (no re-latch).
//  Latency: start sampled at edge t -> enable=1, round_idx=0 in cycle t+1.
//  Unstalled job length: N*(ROUNDS+1)+1 cycles of busy.
//  Counters never wrap: round_idx saturates via the UPDATE transition.
//  block_idx is compared against latched count-1; num_blocks may change after start with no effect.
// TESTING
//  1 block, no stall, ROUNDS=64:
//   - enable high 64 cycles, round_idx 0..63.
//   - load_en high for rounds 0..15 only.
//   - block_done at cycle 65, done at 66, busy low at 67.
//  num_blocks=3: three 64-round bursts each followed by block_done.
//   - block_idx 0,1,2; exactly one done; busy 196 cycles.
//  stall=1 for 5 cycles at round 10:
//   - enable=0, round_idx holds 10.
//   - load_en resumes at 10; done delayed by exactly 5 cycles.
//  abort at round 30 of block 1 (num_blocks=2):
//   - next cycle busy=0, counters 0, no done.
//   - new start accepted immediately.
//  start with num_blocks=0 -> no busy/done.
//  start pulsed during RUN -> ignored, count unchanged.
//  reset asserted together with abort and start mid-RUN:
//   - all outputs 0 next cycle; start on the following cycle runs normally.

Source files
------------

// File: rtl/msg_enable_ctrl_if.sv
// Handshake bundle between top-level control and the SHA-256 message-enable sequencer.
// The master side drives job control; the slave side (the sequencer) drives round strobes.
interface msg_enable_ctrl_if #(
    parameter int RND_W = 6,
    parameter int BLK_W = 8
);
    logic             start;
    logic [BLK_W-1:0] num_blocks;
    logic             stall;
    logic             abort;
    logic             enable;
    logic             load_en;
    logic [RND_W-1:0] round_idx;
    logic [BLK_W-1:0] block_idx;
    logic             block_done;
    logic             done;
    logic             busy;

    modport master (
        output start, num_blocks, stall, abort,
        input  enable, load_en, round_idx, block_idx, block_done, done, busy
    );

    modport slave (
        input  start, num_blocks, stall, abort,
        output enable, load_en, round_idx, block_idx, block_done, done, busy
    );
endinterface

// File: rtl/msg_enable_ctrl.sv
// Message-enable sequencer: steps ROUNDS compression rounds per block, inserts one
// digest-update cycle per block and pulses done after the last block.
module msg_enable_ctrl #(
    parameter int ROUNDS     = 64,
    parameter int LOAD_WORDS = 16,
    parameter int RND_W      = 6,
    parameter int BLK_W      = 8
) (
    input logic              clock,
    input logic              reset,
    msg_enable_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e           state;
    logic [RND_W-1:0] round_q;
    logic [BLK_W-1:0] block_q;
    logic [BLK_W-1:0] count_q;
    logic             block_done_q;
    logic             done_q;
    logic             busy_q;

    logic last_round;
    logic last_block;

    assign last_round = (round_q == RND_W'(ROUNDS - 1));
    assign last_block = (block_q == count_q - BLK_W'(1));

    // Stall is the only input allowed to reach an output combinationally, so the
    // datapath can freeze in the same cycle upstream data goes missing.
    assign bus.enable  = (state == RUN) && !bus.stall;
    // Compare one bit wider so LOAD_WORDS == 2**RND_W cannot truncate to zero.
    assign bus.load_en = bus.enable &&
                         ((RND_W+1)'(round_q) < (RND_W+1)'(LOAD_WORDS));

    assign bus.round_idx  = round_q;
    assign bus.block_idx  = block_q;
    assign bus.block_done = block_done_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;

    // NOTE: all state here is written with non-blocking assignments so every
    // register samples the pre-edge values, matching flop behaviour in simulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            round_q      <= '0;
            block_q      <= '0;
            count_q      <= '0;
            block_done_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.abort) begin
            state        <= IDLE;
            round_q      <= '0;
            block_q      <= '0;
            count_q      <= '0;
            block_done_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            block_done_q <= 1'b0;
            done_q       <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start && (bus.num_blocks != '0)) begin
                        state   <= RUN;
                        count_q <= bus.num_blocks;
                        round_q <= '0;
                        block_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                RUN: begin
                    if (!bus.stall) begin
                        if (last_round) begin
                            state        <= UPDATE;
                            round_q      <= '0;
                            block_done_q <= 1'b1;
                        end else begin
                            round_q <= round_q + RND_W'(1);
                        end
                    end
                end

                UPDATE: begin
                    if (last_block) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state   <= RUN;
                        block_q <= block_q + BLK_W'(1);
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    block_q <= '0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
